pll_mdrp_ctrl: RTL and testbench
================================

// Module: pll_mdrp_ctrl
// PURPOSE
//  Sequences the PLLA dynamic-reconfiguration port (MDCLK/MDOPC/MDAINC/MDWDI/MDRDO) of Gowin_PLL_MOD.
//  - Converts a single-outstanding register read/write command stream into MDRP phase sequences.
//  - On request, runs the post-reconfig PLL reset/relock sequence and reports lock or timeout.
//  - Sits between the system-clock config logic and the PLL instance; runs on the free-running system clock.
// PARAMETERS
//  MDCLK_DIV     4        clk cycles per mdclk half-period (>=1); one MDRP phase = 2*MDCLK_DIV clk
//  RST_CYCLES    16       clk cycles pll_reset is held high during relock (>=1)
//  LOCK_TIMEOUT  65535    clk cycles allowed for synced lock after pll_reset release
// PORTS
//  clk          in   1  system clock; all logic on its rising edge
//  reset        in   1  synchronous, active-high reset
//  cmd_valid    in   1  command request
//  cmd_ready    out  1  controller idle, accepts command this cycle
//  cmd_write    in   1  1 = register write, 0 = register read
//  cmd_relock   in   1  1 = run relock sequence only (addr/data ignored)
//  cmd_addr     in   7  MDRP register address
//  cmd_wdata    in   8  write data
//  rsp_valid    out  1  one-cycle pulse: command finished
//  rsp_rdata    out  8  read data (valid with rsp_valid after a read; held until next read)
//  rsp_err      out  1  with rsp_valid: relock timed out
//  mdclk        out  1  to PLL MDCLK
//  mdopc        out  2  to PLL MDOPC
//  mdainc       out  1  to PLL MDAINC (always 0; no auto-increment bursts)
//  mdwdi        out  8  to PLL MDWDI
//  mdrdo        in   8  from PLL MDRDO
//  pll_reset    out  1  to PLL RESET
//  pll_lock     in   1  from PLL LOCK (asynchronous; 2-flop synchronised internally)
//  locked       out  1  synchronised lock, masked low while relock runs
// BEHAVIOUR
//  - Reset values: cmd_ready 0 for the reset cycle then 1; rsp_valid 0, rsp_rdata 0, rsp_err 0, mdclk 0, mdopc NOP,
//    mdainc 0, mdwdi 0, pll_reset 0, locked 0. Reset mid-operation aborts instantly to IDLE, no response emitted.
//  - mdclk toggles every MDCLK_DIV clk only in ADDR/DATA/CAPT; held 0 elsewhere.
//  - mdopc/mdwdi change only when mdclk falls; PLL samples on mdclk rising edge.
//  - Handshake: command accepted when cmd_valid && cmd_ready; cmd_ready high only in IDLE;
//    fields latched at acceptance, input changes afterwards ignored.
//  - FSM states:
//    IDLE  -> ADDR on accepted read/write; -> PRST on accepted relock.
//    ADDR  one mdclk period, mdopc=OPC_ADDR, mdwdi={1'b0,addr} -> DATA.
//    DATA  one period; write: mdopc=OPC_WR, mdwdi=wdata -> RESP; read: mdopc=OPC_RD, mdwdi=0 -> CAPT.
//    CAPT  one period, mdopc=NOP; mdrdo sampled into rsp_rdata at the final clk of the period -> RESP.
//    PRST  pll_reset=1 for RST_CYCLES clk, locked forced 0 -> WLCK.
//    WLCK  counter from 0; synced lock high -> RESP, err=0; counter reaching LOCK_TIMEOUT first -> RESP, err=1.
//    RESP  rsp_valid=1 for exactly one clk, mdopc NOP -> IDLE.
//  - Latency from accept: write 2 phases + 1; read 3 phases + 1
//    (MDCLK_DIV=4: write 17, read 25 clk to rsp_valid).
//  - Lock seen on the very first WLCK cycle counts as success.
//    Lock and timeout in the same cycle -> success.
//  - Timeout counter width = $clog2(LOCK_TIMEOUT+1), no wrap.
//  - Phase counter is $clog2(2*MDCLK_DIV) bits, resets on each state entry.
//  - rsp_err is 0 for read/write responses.
//  - locked = sync_lock && !(state in PRST/WLCK).
//    Lock drop while IDLE is reflected on locked; no auto-relock.
// STRUCTURE
//  - Package pll_mdrp_pkg:
//    - MDOPC constants OPC_NOP=2'b00, OPC_WR=2'b01, OPC_RD=2'b10, OPC_ADDR=2'b11.
//    - State enum encoding.
//  - One sub-module: pll_mdrp_sync2 (2-flop synchroniser, reset low) for pll_lock.
//  - FSM, phase counter, timeout counter and output registers live in the top; all outputs are registered.
// TESTING (PLL MDRP/LOCK modelled by bench; MDCLK_DIV=4, RST_CYCLES=16, LOCK_TIMEOUT=100)
//  1. Write addr 0x12 data 0xA5
//     -> rising mdclk #1 sees mdopc=11/mdwdi=0x12, #2 sees 01/0xA5; rsp_valid 17 clk after accept, err=0.
//  2. Read addr 0x05, model mdrdo=0x3C after RD
//     -> rsp_rdata=0x3C with rsp_valid 25 clk after accept; rdata holds 0x3C afterwards.
//  3. Relock, lock rises 40 clk after reset release
//     -> pll_reset high exactly 16 clk; locked 0 throughout; rsp_valid, err=0; locked 1 next cycle.
//  4. Relock, lock never rises
//     -> rsp_valid with rsp_err=1 after 100 WLCK clk; locked stays 0.
//  5. cmd_valid held high with changing fields during a write
//     -> cmd_ready 0, single response, latched values on MDWDI; next command accepted the cycle after RESP.
//  6. Assert reset during DATA phase of a write
//     -> next clk: mdclk 0, mdopc 00, pll_reset 0, cmd_ready 1 the cycle after reset drops, no rsp_valid.

Source files
------------

// File: rtl/pll_mdrp_pkg.sv
// Shared definitions for the PLL MDRP controller: MDOPC opcodes and FSM state encoding.
package pll_mdrp_pkg;

  localparam logic [1:0] OPC_NOP  = 2'b00;
  localparam logic [1:0] OPC_WR   = 2'b01;
  localparam logic [1:0] OPC_RD   = 2'b10;
  localparam logic [1:0] OPC_ADDR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_DATA = 3'd2,
    ST_CAPT = 3'd3,
    ST_PRST = 3'd4,
    ST_WLCK = 3'd5,
    ST_RESP = 3'd6
  } state_e;

endpackage

// File: rtl/pll_mdrp_sync2.sv
// Two-flop synchroniser bringing the asynchronous PLL lock into the system clock domain.
module pll_mdrp_sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], d_i};
    end
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/pll_mdrp_ctrl.sv
// Sequences Gowin PLLA MDRP accesses (address/write/read phases on mdclk) and the
// post-reconfiguration PLL reset/relock handshake, one command outstanding at a time.
module pll_mdrp_ctrl
  import pll_mdrp_pkg::*;
#(
  parameter int MDCLK_DIV    = 4,
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_TIMEOUT = 65535
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_write,
  input  logic       cmd_relock,
  input  logic [6:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  output logic       mdclk,
  output logic [1:0] mdopc,
  output logic       mdainc,
  output logic [7:0] mdwdi,
  input  logic [7:0] mdrdo,
  output logic       pll_reset,
  input  logic       pll_lock,
  output logic       locked
);

  localparam int PH_W = (2 * MDCLK_DIV > 1) ? $clog2(2 * MDCLK_DIV) : 1;
  localparam int RC_W = $clog2(RST_CYCLES + 1);
  localparam int TO_W = $clog2(LOCK_TIMEOUT + 1);

  localparam logic [PH_W-1:0] PH_HALF = PH_W'(MDCLK_DIV - 1);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(2 * MDCLK_DIV - 1);
  localparam logic [RC_W-1:0] RC_LAST = RC_W'(RST_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(LOCK_TIMEOUT - 1);

  state_e          state_q;
  logic [PH_W-1:0] phase_q;
  logic [RC_W-1:0] rst_cnt_q;
  logic [TO_W-1:0] to_cnt_q;
  logic            write_q;
  logic [7:0]      wdata_q;

  logic            cmd_ready_q;
  logic            rsp_valid_q;
  logic [7:0]      rsp_rdata_q;
  logic            rsp_err_q;
  logic            mdclk_q;
  logic [1:0]      mdopc_q;
  logic [7:0]      mdwdi_q;
  logic            pll_reset_q;
  logic            locked_q;

  logic            sync_lock;

  pll_mdrp_sync2 u_lock_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (pll_lock),
    .q_o   (sync_lock)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      phase_q     <= '0;
      rst_cnt_q   <= '0;
      to_cnt_q    <= '0;
      write_q     <= 1'b0;
      wdata_q     <= 8'h00;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 8'h00;
      rsp_err_q   <= 1'b0;
      mdclk_q     <= 1'b0;
      mdopc_q     <= OPC_NOP;
      mdwdi_q     <= 8'h00;
      pll_reset_q <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      locked_q    <= sync_lock && (state_q != ST_PRST) && (state_q != ST_WLCK);

      case (state_q)
        ST_IDLE: begin
          cmd_ready_q <= 1'b1;
          if (cmd_valid && cmd_ready_q) begin
            cmd_ready_q <= 1'b0;
            write_q     <= cmd_write;
            wdata_q     <= cmd_wdata;
            if (cmd_relock) begin
              state_q     <= ST_PRST;
              rst_cnt_q   <= '0;
              pll_reset_q <= 1'b1;
              // Mask immediately so locked never shows a stale 1 during relock.
              locked_q    <= 1'b0;
            end else begin
              state_q <= ST_ADDR;
              phase_q <= '0;
              mdopc_q <= OPC_ADDR;
              mdwdi_q <= {1'b0, cmd_addr};
            end
          end
        end

        ST_ADDR, ST_DATA, ST_CAPT: begin
          phase_q <= phase_q + PH_W'(1);
          if (phase_q == PH_HALF) begin
            mdclk_q <= 1'b1;
          end
          // mdopc/mdwdi only move together with the mdclk falling edge.
          if (phase_q == PH_LAST) begin
            mdclk_q <= 1'b0;
            phase_q <= '0;
            if (state_q == ST_ADDR) begin
              state_q <= ST_DATA;
              mdopc_q <= write_q ? OPC_WR : OPC_RD;
              mdwdi_q <= write_q ? wdata_q : 8'h00;
            end else if (state_q == ST_DATA && write_q) begin
              state_q     <= ST_RESP;
              rsp_valid_q <= 1'b1;
              mdopc_q     <= OPC_NOP;
            end else if (state_q == ST_DATA) begin
              state_q <= ST_CAPT;
              mdopc_q <= OPC_NOP;
            end else begin
              state_q     <= ST_RESP;
              rsp_valid_q <= 1'b1;
              rsp_rdata_q <= mdrdo;
            end
          end
        end

        ST_PRST: begin
          rst_cnt_q <= rst_cnt_q + RC_W'(1);
          if (rst_cnt_q == RC_LAST) begin
            state_q     <= ST_WLCK;
            pll_reset_q <= 1'b0;
            to_cnt_q    <= '0;
          end
        end

        ST_WLCK: begin
          to_cnt_q <= to_cnt_q + TO_W'(1);
          // Lock wins over a simultaneous timeout.
          if (sync_lock) begin
            state_q     <= ST_RESP;
            rsp_valid_q <= 1'b1;
          end else if (to_cnt_q == TO_LAST) begin
            state_q     <= ST_RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
          end
        end

        ST_RESP: begin
          state_q     <= ST_IDLE;
          cmd_ready_q <= 1'b1;
          mdopc_q     <= OPC_NOP;
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign mdclk     = mdclk_q;
  assign mdopc     = mdopc_q;
  assign mdainc    = 1'b0;
  assign mdwdi     = mdwdi_q;
  assign pll_reset = pll_reset_q;
  assign locked    = locked_q;

endmodule

// File: tb/tb_pll_mdrp_ctrl.sv
// Directed bench for pll_mdrp_ctrl with a small MDRP register-file model and a scripted PLL lock.
module tb_pll_mdrp_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_write;
  logic       cmd_relock;
  logic [6:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic       mdclk;
  logic [1:0] mdopc;
  logic       mdainc;
  logic [7:0] mdwdi;
  logic [7:0] mdrdo = 8'h00;
  logic       pll_reset;
  logic       pll_lock;
  logic       locked;

  int n_cmp = 0;
  int n_bad = 0;

  pll_mdrp_ctrl #(
    .MDCLK_DIV    (4),
    .RST_CYCLES   (16),
    .LOCK_TIMEOUT (100)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_relock (cmd_relock),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mdclk      (mdclk),
    .mdopc      (mdopc),
    .mdainc     (mdainc),
    .mdwdi      (mdwdi),
    .mdrdo      (mdrdo),
    .pll_reset  (pll_reset),
    .pll_lock   (pll_lock),
    .locked     (locked)
  );

  always #5 clk = ~clk;

  // PLL MDRP model: logs every rising mdclk and acts on the opcode like the PLL would.
  logic [1:0] log_opc [0:63];
  logic [7:0] log_wdi [0:63];
  int         log_n = 0;
  logic [7:0] mem [0:127];
  logic [6:0] mdl_addr = 7'h00;
  bit         seeded = 1'b0;

  always @(posedge mdclk) begin
    if (!seeded) begin
      for (int i = 0; i < 128; i++) mem[i] = 8'h00;
      mem[5] = 8'h3C;
      seeded = 1'b1;
    end
    if (log_n < 64) begin
      log_opc[log_n] = mdopc;
      log_wdi[log_n] = mdwdi;
    end
    log_n++;
    case (mdopc)
      2'b11:   mdl_addr = mdwdi[6:0];
      2'b01:   mem[mdl_addr] = mdwdi;
      2'b10:   mdrdo = mem[mdl_addr];
      default: ;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive a command at the current negedge; it is accepted at the next rising edge.
  task automatic send(input logic wr, input logic rl, input logic [6:0] a, input logic [7:0] d);
    check("ready_before_cmd", 32'(cmd_ready), 32'd1);
    cmd_write  = wr;
    cmd_relock = rl;
    cmd_addr   = a;
    cmd_wdata  = d;
    cmd_valid  = 1'b1;
  endtask

  // Cycle count runs from the accept cycle (0) to the cycle where rsp_valid is seen.
  task automatic wait_rsp(input int start, input int limit, output int cyc);
    cyc = start;
    while (!rsp_valid && cyc < limit) begin
      @(negedge clk);
      cyc++;
      cmd_valid = 1'b0;
    end
  endtask

  int cyc, base, rst_hi, rel, locked_bad, rsp_cnt, ready_bad, rsp_at;
  bit got;

  task automatic relock_run(input int lock_after);
    rst_hi = 0; rel = 0; locked_bad = 0; cyc = 0; got = 1'b0;
    while (!got && cyc < 300) begin
      @(negedge clk);
      cyc++;
      cmd_valid = 1'b0;
      if (rsp_valid) begin
        got = 1'b1;
      end else begin
        if (pll_reset) rst_hi++;
        else if (rst_hi > 0) begin
          rel++;
          if (lock_after > 0 && rel == lock_after) pll_lock = 1'b1;
        end
        if (locked) locked_bad++;
      end
    end
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_relock = 1'b0;
    cmd_addr = 7'h00; cmd_wdata = 8'h00; pll_lock = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", 32'(rsp_rdata), 32'h00);
    check("rst_rsp_err",   32'(rsp_err),   32'd0);
    check("rst_mdclk",     32'(mdclk),     32'd0);
    check("rst_mdopc",     32'(mdopc),     32'd0);
    check("rst_mdainc",    32'(mdainc),    32'd0);
    check("rst_mdwdi",     32'(mdwdi),     32'h00);
    check("rst_pll_reset", 32'(pll_reset), 32'd0);
    check("rst_locked",    32'(locked),    32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 32'(cmd_ready), 32'd1);

    // 1: write 0x12 <- 0xA5
    base = log_n;
    send(1'b1, 1'b0, 7'h12, 8'hA5);
    wait_rsp(0, 40, cyc);
    $display("txn write addr=12 data=a5 latency=%0d err=%0d", cyc, rsp_err);
    check("wr_latency", 32'(cyc), 32'd17);
    check("wr_err", 32'(rsp_err), 32'd0);
    check("wr_rises", 32'(log_n - base), 32'd2);
    check("wr_opc0", 32'(log_opc[base]), 32'h3);
    check("wr_wdi0", 32'(log_wdi[base]), 32'h12);
    check("wr_opc1", 32'(log_opc[base + 1]), 32'h1);
    check("wr_wdi1", 32'(log_wdi[base + 1]), 32'hA5);
    @(negedge clk);
    check("wr_pulse_one", 32'(rsp_valid), 32'd0);
    check("wr_ready_back", 32'(cmd_ready), 32'd1);
    @(negedge clk);

    // 2: read 0x05 (model holds 0x3C)
    base = log_n;
    send(1'b0, 1'b0, 7'h05, 8'h00);
    wait_rsp(0, 40, cyc);
    $display("txn read addr=05 rdata=%02h latency=%0d", rsp_rdata, cyc);
    check("rd_latency", 32'(cyc), 32'd25);
    check("rd_rdata", 32'(rsp_rdata), 32'h3C);
    check("rd_err", 32'(rsp_err), 32'd0);
    check("rd_rises", 32'(log_n - base), 32'd3);
    check("rd_opc0", 32'(log_opc[base]), 32'h3);
    check("rd_wdi0", 32'(log_wdi[base]), 32'h05);
    check("rd_opc1", 32'(log_opc[base + 1]), 32'h2);
    check("rd_wdi1", 32'(log_wdi[base + 1]), 32'h00);
    check("rd_opc2", 32'(log_opc[base + 2]), 32'h0);
    repeat (2) @(negedge clk);

    // rdata must survive an intervening write
    send(1'b1, 1'b0, 7'h40, 8'h99);
    wait_rsp(0, 40, cyc);
    $display("txn write addr=40 data=99 latency=%0d", cyc);
    check("wr2_latency", 32'(cyc), 32'd17);
    check("rdata_hold", 32'(rsp_rdata), 32'h3C);
    repeat (2) @(negedge clk);

    send(1'b0, 1'b0, 7'h12, 8'h00);
    wait_rsp(0, 40, cyc);
    $display("txn read addr=12 rdata=%02h latency=%0d", rsp_rdata, cyc);
    check("rd2_latency", 32'(cyc), 32'd25);
    check("rd2_rdata", 32'(rsp_rdata), 32'hA5);
    repeat (2) @(negedge clk);

    // 3: relock, lock 40 clk after reset release
    base = log_n;
    send(1'b0, 1'b1, 7'h7F, 8'hFF);
    relock_run(40);
    $display("txn relock latency=%0d err=%0d reset_cycles=%0d", cyc, rsp_err, rst_hi);
    check("rl_latency", 32'(cyc), 32'd59);
    check("rl_err", 32'(rsp_err), 32'd0);
    check("rl_reset_len", 32'(rst_hi), 32'd16);
    check("rl_locked_mask", 32'(locked_bad), 32'd0);
    check("rl_no_mdclk", 32'(log_n - base), 32'd0);
    @(negedge clk);
    check("rl_locked_after", 32'(locked), 32'd1);
    check("rl_pulse_one", 32'(rsp_valid), 32'd0);

    // lock loss while idle is reflected on locked
    repeat (2) @(negedge clk);
    check("idle_locked", 32'(locked), 32'd1);
    pll_lock = 1'b0;
    repeat (4) @(negedge clk);
    check("idle_lock_drop", 32'(locked), 32'd0);

    // 4: relock with lock never returning
    send(1'b0, 1'b1, 7'h00, 8'h00);
    relock_run(0);
    $display("txn relock latency=%0d err=%0d reset_cycles=%0d", cyc, rsp_err, rst_hi);
    check("to_latency", 32'(cyc), 32'd117);
    check("to_err", 32'(rsp_err), 32'd1);
    check("to_reset_len", 32'(rst_hi), 32'd16);
    check("to_locked_mask", 32'(locked_bad), 32'd0);
    @(negedge clk);
    check("to_locked_after", 32'(locked), 32'd0);
    @(negedge clk);

    // 5: cmd_valid held with changing fields during a write
    base = log_n;
    send(1'b1, 1'b0, 7'h21, 8'h5A);
    rsp_cnt = 0; ready_bad = 0; rsp_at = 0;
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk);
      if (rsp_valid) begin
        rsp_cnt++;
        rsp_at = c;
      end
      if (c <= 17) begin
        if (cmd_ready) ready_bad++;
        cmd_addr   = 7'(c * 3 + 1);
        cmd_wdata  = 8'(c * 29);
        cmd_write  = c[0];
        cmd_relock = c[1];
      end
    end
    $display("txn held-valid write addr=21 data=5a responses=%0d at=%0d", rsp_cnt, rsp_at);
    check("hold_rsp_count", 32'(rsp_cnt), 32'd1);
    check("hold_rsp_at", 32'(rsp_at), 32'd17);
    check("hold_ready_low", 32'(ready_bad), 32'd0);
    check("hold_opc0", 32'(log_opc[base]), 32'h3);
    check("hold_wdi0", 32'(log_wdi[base]), 32'h21);
    check("hold_opc1", 32'(log_opc[base + 1]), 32'h1);
    check("hold_wdi1", 32'(log_wdi[base + 1]), 32'h5A);
    check("hold_ready_next", 32'(cmd_ready), 32'd1);
    cmd_write = 1'b0; cmd_relock = 1'b0; cmd_addr = 7'h21; cmd_wdata = 8'h00;
    wait_rsp(0, 40, cyc);
    $display("txn read addr=21 rdata=%02h latency=%0d", rsp_rdata, cyc);
    check("hold_rd_latency", 32'(cyc), 32'd25);
    check("hold_rd_rdata", 32'(rsp_rdata), 32'h5A);
    repeat (2) @(negedge clk);

    // 6: reset during the DATA phase of a write
    send(1'b1, 1'b0, 7'h30, 8'h77);
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
    end
    check("mid_mdclk_high", 32'(mdclk), 32'd1);
    check("mid_mdopc_wr", 32'(mdopc), 32'h1);
    reset = 1'b1;
    @(negedge clk);
    check("abort_mdclk", 32'(mdclk), 32'd0);
    check("abort_mdopc", 32'(mdopc), 32'd0);
    check("abort_pll_reset", 32'(pll_reset), 32'd0);
    check("abort_ready", 32'(cmd_ready), 32'd0);
    check("abort_rsp", 32'(rsp_valid), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("abort_ready_back", 32'(cmd_ready), 32'd1);
    rsp_cnt = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (rsp_valid) rsp_cnt++;
    end
    $display("txn aborted write addr=30 responses=%0d", rsp_cnt);
    check("abort_no_rsp", 32'(rsp_cnt), 32'd0);

    send(1'b0, 1'b0, 7'h12, 8'h00);
    wait_rsp(0, 40, cyc);
    $display("txn read addr=12 rdata=%02h latency=%0d", rsp_rdata, cyc);
    check("post_rd_latency", 32'(cyc), 32'd25);
    check("post_rd_rdata", 32'(rsp_rdata), 32'hA5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
